// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// The unit itself connects through the slave modport; the CPU side and memory model use master.
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int B = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [B-1:0]      mem_we;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte-lane strobes, beat alignment, two-beat split of
// line-crossing accesses, load extension and misalign/size/timeout error reporting.
module load_store_unit #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int TIMEOUT          = 255
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam int B     = XLEN / 8;
    localparam int OFF_W = $clog2(B);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // Keep the low 8<<size bits; sign-extend from the top kept bit unless unsigned.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      size,
                                                    input logic            uns);
        int              nb;
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] top;
        logic            sgn;
        nb   = ((32'sd8 << size) > XLEN) ? XLEN : (32'sd8 << size);
        mask = {XLEN{1'b1}} >> (XLEN - nb);
        top  = mask ^ (mask >> 1);
        sgn  = (|(raw & top)) & ~uns;
        return (raw & mask) | (sgn ? ~mask : {XLEN{1'b0}});
    endfunction

    logic [1:0]        state_r;
    logic [7:0]        tmo_cnt_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [OFF_W-1:0]  off_r;
    logic              split_r;
    logic [B-1:0]      beat1_we_r;
    logic [XLEN-1:0]   beat1_wdata_r;
    logic [XLEN-1:0]   beat0_rdata_r;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic              resp_err_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [B-1:0]      mem_we_r;
    logic [XLEN-1:0]   mem_wdata_r;

    logic [1:0]        size_s;
    logic [OFF_W-1:0]  off_s;
    int                n_s;
    logic              split_s;
    logic              reject_s;
    logic [2*B-1:0]    lane_full_s;
    logic [2*XLEN-1:0] wdata_full_s;
    logic [XLEN-1:0]   lo_rdata_s;
    logic [2*XLEN-1:0] rdata_pair_s;
    logic [XLEN-1:0]   load_s;

    // Decode the incoming request: lane strobes and shifted data for both beats.
    always_comb begin
        size_s       = bus.req_type[1:0];
        off_s        = bus.req_addr[OFF_W-1:0];
        n_s          = 32'sd1 << size_s;
        split_s      = (int'(off_s) + n_s) > B;
        reject_s     = ((size_s == 2'b11) && (XLEN < 64)) || (split_s && (ALLOW_MISALIGNED == 0));
        lane_full_s  = ({(2*B){1'b1}} >> (2*B - n_s)) << off_s;
        wdata_full_s = {{XLEN{1'b0}}, bus.req_wdata} << {off_s, 3'b000};
    end

    // Reassemble load data from one or two beats and extend it.
    always_comb begin
        lo_rdata_s   = split_r ? beat0_rdata_r : bus.mem_rdata;
        rdata_pair_s = {bus.mem_rdata, lo_rdata_s} >> {off_r, 3'b000};
        load_s       = extend_load(rdata_pair_s[XLEN-1:0], size_r, uns_r);
    end

    // Access sequencer; every bus and response output is registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            tmo_cnt_r     <= 8'd0;
            we_r          <= 1'b0;
            size_r        <= 2'd0;
            uns_r         <= 1'b0;
            off_r         <= {OFF_W{1'b0}};
            split_r       <= 1'b0;
            beat1_we_r    <= {B{1'b0}};
            beat1_wdata_r <= {XLEN{1'b0}};
            beat0_rdata_r <= {XLEN{1'b0}};
            req_ready_r   <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= {XLEN{1'b0}};
            resp_err_r    <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_we_r      <= {B{1'b0}};
            mem_wdata_r   <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    req_ready_r <= 1'b1;
                    if (bus.req_valid && req_ready_r) begin
                        req_ready_r   <= 1'b0;
                        we_r          <= bus.req_we;
                        size_r        <= size_s;
                        uns_r         <= bus.req_type[2];
                        off_r         <= off_s;
                        split_r       <= split_s;
                        tmo_cnt_r     <= 8'd0;
                        beat1_we_r    <= bus.req_we ? lane_full_s[2*B-1:B] : {B{1'b0}};
                        beat1_wdata_r <= wdata_full_s[2*XLEN-1:XLEN];
                        if (reject_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else begin
                            state_r     <= BEAT0;
                            mem_req_r   <= 1'b1;
                            mem_addr_r  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_we_r    <= bus.req_we ? lane_full_s[B-1:0] : {B{1'b0}};
                            mem_wdata_r <= wdata_full_s[XLEN-1:0];
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus.mem_ack) begin
                        tmo_cnt_r <= 8'd0;
                        if ((state_r == BEAT0) && split_r) begin
                            state_r       <= BEAT1;
                            beat0_rdata_r <= bus.mem_rdata;
                            mem_addr_r    <= mem_addr_r + ADDR_W'(B);
                            mem_we_r      <= beat1_we_r;
                            mem_wdata_r   <= beat1_wdata_r;
                        end else begin
                            state_r      <= RESP;
                            mem_req_r    <= 1'b0;
                            mem_addr_r   <= {ADDR_W{1'b0}};
                            mem_we_r     <= {B{1'b0}};
                            mem_wdata_r  <= {XLEN{1'b0}};
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= we_r ? {XLEN{1'b0}} : load_s;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Beat abandoned; a pending second beat is never issued.
                        state_r      <= RESP;
                        mem_req_r    <= 1'b0;
                        mem_addr_r   <= {ADDR_W{1'b0}};
                        mem_we_r     <= {B{1'b0}};
                        mem_wdata_r  <= {XLEN{1'b0}};
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= {XLEN{1'b0}};
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {XLEN{1'b0}};
                    req_ready_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wdata  = mem_wdata_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, a scripted memory model
// checking each bus beat, and a monitor comparing responses against queued expectations.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   memreq_cnt = 0;
    int   na_resp_cnt = 0;
    bit   na_memreq_seen = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } beat_t;

    exp_t  expq[$];
    beat_t beatq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();
    load_store_unit_if #(.XLEN(32), .ADDR_W(32)) bus_na ();

    load_store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    load_store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT(4)) u_dut_na (
        .clk (clk),
        .rst (rst),
        .bus (bus_na)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scripted memory: checks each beat every cycle it is presented, acks after its delay.
    initial begin
        bit ack_now = 1'b0;
        int waitc   = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (ack_now) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h0;
                void'(beatq.pop_front());
                ack_now = 1'b0;
                waitc   = 0;
            end
            if (bus.mem_req) memreq_cnt++;
            if (bus.mem_req && (beatq.size() > 0)) begin
                chk("mem_addr", bus.mem_addr, beatq[0].addr);
                chk("mem_we", bus.mem_we, beatq[0].we);
                chk("mem_wdata", bus.mem_wdata, beatq[0].wdata);
                if (waitc == beatq[0].delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = beatq[0].rdata;
                    ack_now       = 1'b1;
                end else begin
                    waitc++;
                end
            end
        end
    end

    // Response monitor: pops the oldest expectation on every resp_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got resp_valid with rdata 0x%0h err %0b, expected none",
                             bus.resp_rdata, bus.resp_err);
                end else begin
                    e = expq.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_err", bus.resp_err, e.err);
                    chk("resp_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Monitor for the misalign-disallowed instance; its memory never acks.
    initial begin
        bus_na.mem_ack   = 1'b0;
        bus_na.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_na.mem_req) na_memreq_seen = 1'b1;
            if (bus_na.resp_valid) begin
                na_resp_cnt++;
                chk("na_resp_err", bus_na.resp_err, 1'b1);
                chk("na_resp_rdata", bus_na.resp_rdata, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                             input int delay, input logic [31:0] rdata);
        beat_t b;
        b.addr = addr; b.we = we; b.wdata = wdata; b.delay = delay; b.rdata = rdata;
        beatq.push_back(b);
    endtask

    task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata_exp,
                         input logic err_exp, input int lat);
        exp_t e;
        bit   acc = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_type  = typ;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int i = 0; (i < 40) && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready) acc = 1'b1;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1 within 40 cycles");
        end else begin
            e.rdata = rdata_exp; e.err = err_exp; e.lat = lat; e.acc = cyc;
            expq.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; (i < 60) && (expq.size() > 0); i++) @(negedge clk);
        chk("pending_resp", expq.size(), 0);
        @(negedge clk);
        chk("pending_beats", beatq.size(), 0);
    endtask

    initial begin
        bit acc;
        int snap;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus_na.req_valid = 1'b0; bus_na.req_we = 1'b0; bus_na.req_type = 3'b000;
        bus_na.req_addr = 32'h0; bus_na.req_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1'b1);

        // Aligned word store, immediate ack
        push_beat(32'h1000, 4'b1111, 32'h11223344, 0, 32'h0);
        issue(1'b1, 3'b010, 32'h1000, 32'h11223344, 32'h0, 1'b0, 2);
        drain();
        // Byte store into the top lane
        push_beat(32'h1000, 4'b1000, 32'hAB000000, 0, 32'h0);
        issue(1'b1, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 1'b0, 2);
        drain();
        // Halfword loads, signed and unsigned
        push_beat(32'h1000, 4'b0000, 32'h0, 0, 32'h80015555);
        issue(1'b0, 3'b001, 32'h1002, 32'h0, 32'hFFFF8001, 1'b0, 2);
        drain();
        push_beat(32'h1000, 4'b0000, 32'h0, 0, 32'h80015555);
        issue(1'b0, 3'b101, 32'h1002, 32'h0, 32'h00008001, 1'b0, 2);
        drain();
        // Misaligned word load split over two beats
        push_beat(32'h1004, 4'b0000, 32'h0, 0, 32'hAABB1111);
        push_beat(32'h1008, 4'b0000, 32'h0, 0, 32'h2222CCDD);
        issue(1'b0, 3'b010, 32'h1006, 32'h0, 32'hCCDDAABB, 1'b0, 3);
        drain();
        // Misaligned halfword store split: lane 3 then lane 0
        push_beat(32'h1000, 4'b1000, 32'hEF000000, 0, 32'h0);
        push_beat(32'h1004, 4'b0001, 32'h000000BE, 0, 32'h0);
        issue(1'b1, 3'b001, 32'h1003, 32'h0000BEEF, 32'h0, 1'b0, 3);
        drain();
        // Split at the top of the address space wraps to 0
        push_beat(32'hFFFFFFFC, 4'b0000, 32'h0, 0, 32'h12345678);
        push_beat(32'h00000000, 4'b0000, 32'h0, 0, 32'h9ABCDEF0);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'hDEF01234, 1'b0, 3);
        drain();
        // Signed byte load with two wait cycles
        push_beat(32'h2000, 4'b0000, 32'h0, 2, 32'h00009900);
        issue(1'b0, 3'b000, 32'h2001, 32'h0, 32'hFFFFFF99, 1'b0, 4);
        drain();
        // Doubleword on a 32-bit unit is rejected without a bus beat
        snap = memreq_cnt;
        issue(1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
        drain();
        chk("bad_size_no_mem_req", memreq_cnt - snap, 0);
        // No ack: mem_req held exactly TIMEOUT cycles, then error
        snap = memreq_cnt;
        issue(1'b0, 3'b010, 32'h3000, 32'h0, 32'h0, 1'b1, 5);
        drain();
        chk("timeout_mem_req_cycles", memreq_cnt - snap, 4);

        // Misaligned access on the instance that disallows splitting
        @(posedge clk); #1;
        bus_na.req_valid = 1'b1; bus_na.req_we = 1'b0; bus_na.req_type = 3'b010;
        bus_na.req_addr = 32'h1006;
        acc = 1'b0;
        for (int i = 0; (i < 20) && !acc; i++) begin
            @(negedge clk);
            if (bus_na.req_ready) acc = 1'b1;
        end
        @(posedge clk); #1 bus_na.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("na_resp_count", na_resp_cnt, 1);
        chk("na_mem_req_seen", na_memreq_seen, 1'b0);

        // Reset while the first beat waits for an ack
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_type = 3'b010; bus.req_addr = 32'h4000;
        acc = 1'b0;
        for (int i = 0; (i < 20) && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready) acc = 1'b1;
        end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("beat0_mem_req", bus.mem_req, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mem_req", bus.mem_req, 1'b0);
        chk("rst_mid_resp_valid", bus.resp_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ready", bus.req_ready, 1'b1);

        // Unit recovers for a normal access
        push_beat(32'h5000, 4'b1111, 32'hCAFEF00D, 0, 32'h0);
        issue(1'b1, 3'b010, 32'h5000, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
